mem_emulator_dp: RTL and testbench

- Parametrised dual-port successor to the single-port buffer emulator used around matrix_mult_wrapper.
- Port A serves the core (ib/wb/ob buffer traffic). Port B serves the external loader/dumper, so the bench no longer needs a cenb/wenb/addr mux on ext_en_i.
- Adds per-lane write masks, configurable read latency with a valid strobe, and deterministic same-address collision handling.
- Adds a hardware clear sweep driven by a small FSM.

---
 rtl/mem_emulator_dp_pkg.sv | 16 +
 rtl/mem_emulator_dp_if.sv | 17 +
 rtl/mem_emulator_dp_rd_pipe.sv | 34 +++
 rtl/mem_emulator_dp.sv | 122 ++++++++++++
 tb/tb_mem_emulator_dp.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_emulator_dp_pkg.sv
// Shared types for the dual-port buffer emulator: clear-sweep states and sizing helpers.
package mem_emulator_dp_pkg;

    localparam int RD_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/mem_emulator_dp_if.sv
// One memory port: active-low SRAM-style request plus registered read data and valid strobe.
interface mem_emulator_dp_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int AW    = 8
);
    logic                   cenb;
    logic                   wenb;
    logic [LANES-1:0]       bwenb;
    logic [AW-1:0]          addr;
    logic [LANES*WIDTH-1:0] d;
    logic [LANES*WIDTH-1:0] q;
    logic                   qvalid;

    modport master (output cenb, wenb, bwenb, addr, d, input q, qvalid);
    modport slave  (input cenb, wenb, bwenb, addr, d, output q, qvalid);
endinterface

// File: rtl/mem_emulator_dp_rd_pipe.sv
// Read-data delay line: RD_LATENCY stages of data/valid; each stage only reloads on valid,
// so the last stage holds the most recent read result.
module mem_rd_pipe #(
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk_i,
    input  logic          rstn_async_i,
    input  logic          vld_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o,
    output logic          vld_o
);
    logic [DW-1:0]         dat_p [RD_LATENCY];
    logic [RD_LATENCY-1:0] vld_p;

    // stage 0 captures the array output at the read edge; later stages shift forward
    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            vld_p <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat_p[i] <= '0;
        end else begin
            vld_p[0] <= vld_i;
            if (vld_i) dat_p[0] <= d_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) dat_p[i] <= dat_p[i-1];
            end
        end
    end

    assign q_o   = dat_p[RD_LATENCY-1];
    assign vld_o = vld_p[RD_LATENCY-1];
endmodule

// File: rtl/mem_emulator_dp.sv
// Dual-port lane-maskable buffer emulator with read-before-write, A-wins collisions,
// pipelined reads and a hardware clear sweep.
module mem_emulator_dp
    import mem_emulator_dp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LANES      = 4,
    parameter int SIZE       = 256,
    parameter int RD_LATENCY = 1,
    localparam int AW        = addr_width(SIZE),
    localparam int DW        = LANES * WIDTH
) (
    input  logic                clk_i,
    input  logic                rstn_async_i,
    mem_emulator_dp_if.slave    port_a,
    mem_emulator_dp_if.slave    port_b,
    input  logic                clr_i,
    output logic                busy_o,
    output logic                coll_o,
    output logic                err_o
);
    typedef struct packed {
        logic             cenb;
        logic             wenb;
        logic [LANES-1:0] bwenb;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    d;
    } mem_port_req_t;

    mem_port_req_t req_a, req_b;
    assign req_a = '{cenb: port_a.cenb, wenb: port_a.wenb, bwenb: port_a.bwenb,
                     addr: port_a.addr, d: port_a.d};
    assign req_b = '{cenb: port_b.cenb, wenb: port_b.wenb, bwenb: port_b.bwenb,
                     addr: port_b.addr, d: port_b.d};

    logic [DW-1:0] mem [SIZE];

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, coll_q;
    logic          busy, a_ok, b_ok, a_rd, b_rd, a_wr, b_wr, same_addr;
    logic [DW-1:0] a_rdata, b_rdata;

    if ((1 << AW) == SIZE) begin : g_pow2
        assign a_ok = 1'b1;
        assign b_ok = 1'b1;
    end else begin : g_npow2
        assign a_ok = int'(req_a.addr) < SIZE;
        assign b_ok = int'(req_b.addr) < SIZE;
    end

    assign busy      = (state_q == CLEAR);
    assign same_addr = (req_a.addr == req_b.addr);
    assign a_rd      = !req_a.cenb &&  req_a.wenb && !busy;
    assign b_rd      = !req_b.cenb &&  req_b.wenb && !busy;
    assign a_wr      = !req_a.cenb && !req_a.wenb && !busy && a_ok;
    assign b_wr      = !req_b.cenb && !req_b.wenb && !busy && b_ok;
    assign a_rdata   = a_ok ? mem[req_a.addr] : '0;
    assign b_rdata   = b_ok ? mem[req_b.addr] : '0;

    // Array update; B only touches lanes that A is not writing at the same address.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (a_wr && !req_a.bwenb[k])
                    mem[req_a.addr][k*WIDTH +: WIDTH] <= req_a.d[k*WIDTH +: WIDTH];
                if (b_wr && !req_b.bwenb[k] && !(a_wr && same_addr && !req_a.bwenb[k]))
                    mem[req_b.addr][k*WIDTH +: WIDTH] <= req_b.d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            coll_q  <= !busy && !req_a.cenb && !req_b.cenb && same_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (clr_i) begin
                state_d = CLEAR;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            CLEAR: begin
                if (!req_a.cenb || !req_b.cenb) err_d = 1'b1;
                if (cnt_q == AW'(SIZE - 1)) state_d = DONE;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = busy;
    assign coll_o = coll_q;
    assign err_o  = err_q;

    mem_rd_pipe #(.DW(DW), .RD_LATENCY(RD_LATENCY)) u_rd_pipe_a (
        .clk_i(clk_i), .rstn_async_i(rstn_async_i),
        .vld_i(a_rd), .d_i(a_rdata), .q_o(port_a.q), .vld_o(port_a.qvalid)
    );

    mem_rd_pipe #(.DW(DW), .RD_LATENCY(RD_LATENCY)) u_rd_pipe_b (
        .clk_i(clk_i), .rstn_async_i(rstn_async_i),
        .vld_i(b_rd), .d_i(b_rdata), .q_o(port_b.q), .vld_o(port_b.qvalid)
    );
endmodule

// File: tb/tb_mem_emulator_dp.sv
// Bench for mem_emulator_dp (SIZE=16, RD_LATENCY=2): directed steps plus random traffic
// checked every cycle against a word-array reference model.
module tb_mem_emulator_dp;
    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int SIZE  = 16;
    localparam int LAT   = 2;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic busy, coll, err;

    always #5 clk = ~clk;

    mem_emulator_dp_if #(.WIDTH(WIDTH), .LANES(LANES), .AW(AW)) pa ();
    mem_emulator_dp_if #(.WIDTH(WIDTH), .LANES(LANES), .AW(AW)) pb ();

    mem_emulator_dp #(.WIDTH(WIDTH), .LANES(LANES), .SIZE(SIZE), .RD_LATENCY(LAT)) dut (
        .clk_i(clk), .rstn_async_i(rst_n), .port_a(pa), .port_b(pb),
        .clr_i(clr), .busy_o(busy), .coll_o(coll), .err_o(err)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] ref_mem [SIZE];
    logic [31:0] exp_qa [int];
    logic [31:0] exp_qb [int];
    logic [31:0] last_qa = '0, last_qb = '0;
    int          edge_n = 0;
    int          clr_edge = -100;
    logic        err_exp = 1'b0, coll_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed=%h expected=%h", tag, edge_n, got, exp);
        end
    endtask

    task automatic drv_a(input logic cenb, input logic wenb, input logic [3:0] bw,
                         input logic [3:0] addr, input logic [31:0] d);
        pa.cenb = cenb; pa.wenb = wenb; pa.bwenb = bw; pa.addr = addr; pa.d = d;
    endtask

    task automatic drv_b(input logic cenb, input logic wenb, input logic [3:0] bw,
                         input logic [3:0] addr, input logic [31:0] d);
        pb.cenb = cenb; pb.wenb = wenb; pb.bwenb = bw; pb.addr = addr; pb.d = d;
    endtask

    task automatic idle_ports();
        drv_a(1'b1, 1'b1, 4'hF, 4'h0, 32'h0);
        drv_b(1'b1, 1'b1, 4'hF, 4'h0, 32'h0);
    endtask

    task automatic model_reset();
        exp_qa.delete(); exp_qb.delete();
        last_qa = '0; last_qb = '0;
        clr_edge = -100; err_exp = 1'b0; coll_exp = 1'b0;
    endtask

    // One clock: apply the model for the coming edge, then compare all outputs at negedge.
    task automatic tick();
        int m;
        logic busy_m, idle_m, va, vb;
        m = edge_n + 1;
        busy_m = (m > clr_edge) && (m <= clr_edge + SIZE);
        idle_m = !busy_m && (m != clr_edge + SIZE + 1);
        coll_exp = 1'b0;
        if (busy_m) begin
            if (!pa.cenb || !pb.cenb) err_exp = 1'b1;
            ref_mem[m - clr_edge - 1] = '0;
        end else begin
            if (!pa.cenb && pa.wenb) exp_qa[m + LAT - 1] = ref_mem[pa.addr];
            if (!pb.cenb && pb.wenb) exp_qb[m + LAT - 1] = ref_mem[pb.addr];
            coll_exp = !pa.cenb && !pb.cenb && (pa.addr == pb.addr);
            for (int k = 0; k < LANES; k++) begin
                logic a_lane;
                a_lane = !pa.cenb && !pa.wenb && !pa.bwenb[k];
                if (a_lane) ref_mem[pa.addr][k*8 +: 8] = pa.d[k*8 +: 8];
                if (!pb.cenb && !pb.wenb && !pb.bwenb[k] && !(a_lane && pa.addr == pb.addr))
                    ref_mem[pb.addr][k*8 +: 8] = pb.d[k*8 +: 8];
            end
        end
        if (idle_m && clr) begin
            clr_edge = m;
            err_exp  = 1'b0;
        end
        @(posedge clk);
        edge_n = m;
        @(negedge clk);
        va = exp_qa.exists(m);
        if (va) begin last_qa = exp_qa[m]; exp_qa.delete(m); end
        vb = exp_qb.exists(m);
        if (vb) begin last_qb = exp_qb[m]; exp_qb.delete(m); end
        chk("busy", busy, (m >= clr_edge) && (m < clr_edge + SIZE));
        chk("coll", coll, coll_exp);
        chk("err", err, err_exp);
        chk("a_qvalid", pa.qvalid, va);
        chk("b_qvalid", pb.qvalid, vb);
        chk("a_q", pa.q, last_qa);
        chk("b_q", pb.q, last_qb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, vrun;
        idle_ports();
        #2;
        chk("rst_a_q", pa.q, 32'h0);
        chk("rst_a_qvalid", pa.qvalid, 1'b0);
        chk("rst_b_qvalid", pb.qvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_coll", coll, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // initial sweep brings the array to a known all-zero state
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < SIZE + 2; i++) tick();

        // write then read with two-cycle latency and hold
        drv_a(1'b0, 1'b0, 4'h0, 4'd5, 32'h11223344); tick();
        drv_a(1'b0, 1'b1, 4'hF, 4'd5, 32'h0);        tick();
        idle_ports();                                 tick();
        chk("rd5_valid", pa.qvalid, 1'b1);
        chk("rd5_data", pa.q, 32'h11223344);
        tick();
        chk("rd5_hold_valid", pa.qvalid, 1'b0);
        chk("rd5_hold_data", pa.q, 32'h11223344);

        // lane mask
        drv_a(1'b0, 1'b0, 4'h0, 4'd7, 32'hAABBCCDD);   tick();
        drv_a(1'b0, 1'b0, 4'b1010, 4'd7, 32'h0);       tick();
        drv_a(1'b0, 1'b1, 4'hF, 4'd7, 32'h0);          tick();
        idle_ports();                                  tick();
        chk("lane_mask", pa.q, 32'hAA00CC00);

        // write/write collision, then read-before-write across ports
        drv_a(1'b0, 1'b0, 4'h0, 4'd9, 32'h1);
        drv_b(1'b0, 1'b0, 4'h0, 4'd9, 32'h2);          tick();
        chk("coll_pulse", coll, 1'b1);
        drv_a(1'b0, 1'b0, 4'h0, 4'd9, 32'h3);
        drv_b(1'b0, 1'b1, 4'hF, 4'd9, 32'h0);          tick();
        chk("coll_rw", coll, 1'b1);
        idle_ports();                                  tick();
        chk("b_rbw_data", pb.q, 32'h1);
        tick();
        chk("coll_clear", coll, 1'b0);

        // random traffic on both ports with occasional clear requests
        for (int i = 0; i < 300; i++) begin
            drv_a(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
                  4'($urandom_range(0, 7)), $urandom);
            drv_b(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
                  4'($urandom_range(0, 7)), $urandom);
            clr = ($urandom_range(0, 49) == 0);
            tick();
        end
        clr = 1'b0; idle_ports();
        for (int i = 0; i < SIZE + 4; i++) tick();

        // clear sweep with a B access in its third cycle
        for (int i = 0; i < SIZE; i++) begin
            drv_a(1'b0, 1'b0, 4'h0, 4'(i), 32'hF00D0000 + 32'(i)); tick();
        end
        idle_ports();
        clr = 1'b1; tick(); clr = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < SIZE + 2; i++) begin
            if (i == 2) drv_b(1'b0, 1'b1, 4'hF, 4'd3, 32'h0);
            else        idle_ports();
            tick();
            if (busy) busy_cnt++;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(SIZE));
        chk("err_sticky", err, 1'b1);

        // streaming reads with data in every word
        for (int i = 0; i < SIZE; i++) begin
            drv_a(1'b0, 1'b0, 4'h0, 4'(i), 32'h5A000000 + 32'(i * 3)); tick();
        end
        vrun = 0;
        for (int i = 0; i < SIZE + LAT; i++) begin
            if (i < SIZE) drv_b(1'b0, 1'b1, 4'hF, 4'(i), 32'h0);
            else          idle_ports();
            idle_ports_a();
            tick();
            if (pb.qvalid) begin
                chk("stream_order", pb.q, 32'h5A000000 + 32'(vrun * 3));
                vrun++;
            end
        end
        chk("stream_count", 32'(vrun), 32'(SIZE));

        // reset in the middle of a sweep
        for (int i = 0; i < SIZE; i++) begin
            drv_a(1'b0, 1'b0, 4'h0, 4'(i), 32'hC0DE0000 + 32'(i)); tick();
        end
        idle_ports();
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_b_q", pb.q, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < SIZE + LAT; i++) begin
            if (i < SIZE) drv_b(1'b0, 1'b1, 4'hF, 4'(i), 32'h0);
            else          idle_ports();
            tick();
        end
        chk("midrst_word4", ref_mem[4], 32'h0);
        chk("midrst_word15", pb.q, 32'hC0DE000F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic idle_ports_a();
        drv_a(1'b1, 1'b1, 4'hF, 4'h0, 32'h0);
    endtask
endmodule
